// File: rtl/alu_flag_unit.sv
// alu_flag_unit: registered ALU with N/Z/V/C condition flags.
// Add, subtract and logic ops finish in one cycle; multiply is an iterative
// shift-add that runs for WIDTH cycles behind a start/busy/done handshake.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start; single-cycle ops complete here
// S_MUL  | shift-add multiply in progress, one multiplier bit per cycle
module alu_flag_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             setFlags,
  output logic [WIDTH-1:0] result,
  output logic             Nflag,
  output logic             Zflag,
  output logic             Vflag,
  output logic             Cflag,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t               state, state_n;
  logic [2*WIDTH-1:0]   acc, acc_n, mcand, mcand_n, acc_step;
  logic [WIDTH-1:0]     mplier, mplier_n, result_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic                 sf_lat, sf_lat_n;
  logic                 n_n, z_n, v_n, c_n, done_n;

  logic [WIDTH-1:0]     b_eff, alu_r;
  logic [WIDTH:0]       sum;
  logic                 alu_v, alu_c, is_sub;

  // Single-cycle datapath; SUB reuses the adder as a + ~b + 1.
  always_comb begin
    is_sub = (op == OP_SUB);
    b_eff  = is_sub ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    alu_r  = a & b;
    alu_v  = 1'b0;
    alu_c  = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_OR:   alu_r = a | b;
      OP_XOR:  alu_r = a ^ b;
      default: alu_r = a & b;
    endcase
  end

  // One shift-add step: conditionally accumulate the shifted multiplicand.
  always_comb begin
    acc_step = acc + (mplier[0] ? mcand : {2*WIDTH{1'b0}});
  end

  // Next-state, datapath and output decode.
  always_comb begin
    state_n  = state;
    acc_n    = acc;
    mcand_n  = mcand;
    mplier_n = mplier;
    cnt_n    = cnt;
    sf_lat_n = sf_lat;
    result_n = result;
    n_n      = Nflag;
    z_n      = Zflag;
    v_n      = Vflag;
    c_n      = Cflag;
    done_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            acc_n    = '0;
            mcand_n  = {{WIDTH{1'b0}}, a};
            mplier_n = b;
            cnt_n    = CW'(WIDTH);
            sf_lat_n = setFlags;
            state_n  = S_MUL;
          end else begin
            result_n = alu_r;
            done_n   = 1'b1;
            if (setFlags) begin
              n_n = alu_r[WIDTH-1];
              z_n = (alu_r == '0);
              v_n = alu_v;
              c_n = alu_c;
            end
          end
        end
      end
      S_MUL: begin
        acc_n    = acc_step;
        mcand_n  = mcand << 1;
        mplier_n = mplier >> 1;
        cnt_n    = cnt - CW'(1);
        // Last iteration: the product is final in acc_step, publish it now.
        if (cnt == CW'(1)) begin
          result_n = acc_step[WIDTH-1:0];
          done_n   = 1'b1;
          state_n  = S_IDLE;
          if (sf_lat) begin
            n_n = acc_step[WIDTH-1];
            z_n = (acc_step[WIDTH-1:0] == '0);
            v_n = |acc_step[2*WIDTH-1:WIDTH];
            c_n = 1'b0;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any multiply in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      sf_lat <= 1'b0;
      result <= '0;
      Nflag  <= 1'b0;
      Zflag  <= 1'b0;
      Vflag  <= 1'b0;
      Cflag  <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      acc    <= acc_n;
      mcand  <= mcand_n;
      mplier <= mplier_n;
      cnt    <= cnt_n;
      sf_lat <= sf_lat_n;
      result <= result_n;
      Nflag  <= n_n;
      Zflag  <= z_n;
      Vflag  <= v_n;
      Cflag  <= c_n;
      done   <= done_n;
    end
  end

  assign busy = (state == S_MUL);

endmodule

// File: tb/tb_alu_flag_unit.sv
// Testbench for alu_flag_unit at WIDTH=8: directed cases plus randomized ops
// checked against an arithmetic reference model.
module tb_alu_flag_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         setFlags = 1'b0;
  logic [W-1:0] result;
  logic         Nflag, Zflag, Vflag, Cflag, busy, done;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] m_res = '0;
  logic [3:0]   m_flags = '0;  // {N,Z,V,C}

  alu_flag_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .setFlags(setFlags), .result(result), .Nflag(Nflag), .Zflag(Zflag),
    .Vflag(Vflag), .Cflag(Cflag), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] dut_flags();
    return {Nflag, Zflag, Vflag, Cflag};
  endfunction

  // Reference: plain integer arithmetic with signed range checks for V.
  function automatic void ref_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] r, output logic v, output logic c);
    int ux, uy, sx, sy, t, half, full;
    half = 1 << (W - 1);
    full = 1 << W;
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= half) ? ux - full : ux;
    sy = (uy >= half) ? uy - full : uy;
    v = 1'b0;
    c = 1'b0;
    case (o)
      3'd0: begin
        t = ux + uy;
        r = W'(t);
        c = (t >= full);
        v = ((sx + sy) > half - 1) || ((sx + sy) < -half);
      end
      3'd1: begin
        t = ux - uy;
        r = W'(t);
        c = (ux >= uy);
        v = ((sx - sy) > half - 1) || ((sx - sy) < -half);
      end
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: begin
        t = ux * uy;
        r = W'(t);
        v = (t >= full);
      end
      default: r = x & y;
    endcase
  endfunction

  task automatic model_apply(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input logic sf);
    logic [W-1:0] r;
    logic v, c;
    ref_op(o, x, y, r, v, c);
    m_res = r;
    if (sf) m_flags = {r[W-1], (r == '0), v, c};
  endtask

  // Entered and left at a falling edge.
  task automatic single(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input logic sf);
    op = o; a = x; b = y; setFlags = sf; start = 1'b1;
    @(posedge clk);
    model_apply(o, x, y, sf);
    @(negedge clk);
    start = 1'b0;
    chk("single_result", {24'd0, result}, {24'd0, m_res});
    chk("single_flags", {28'd0, dut_flags()}, {28'd0, m_flags});
    chk("single_done", {31'd0, done}, 32'd1);
    chk("single_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic mul(input logic [W-1:0] x, input logic [W-1:0] y, input logic sf, input logic poke);
    op = 3'd5; a = x; b = y; setFlags = sf; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      chk("mul_busy", {31'd0, busy}, 32'd1);
      chk("mul_nodone", {31'd0, done}, 32'd0);
      if (poke && i == 2) begin
        op = 3'd0; a = 8'h01; b = 8'h01; setFlags = 1'b1; start = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    model_apply(3'd5, x, y, sf);
    chk("mul_done", {31'd0, done}, 32'd1);
    chk("mul_busy_end", {31'd0, busy}, 32'd0);
    chk("mul_result", {24'd0, result}, {24'd0, m_res});
    chk("mul_flags", {28'd0, dut_flags()}, {28'd0, m_flags});
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    @(negedge clk);
    chk("idle_nodone", {31'd0, done}, 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_result"}, {24'd0, result}, 32'd0);
    chk({tag, "_flags"}, {28'd0, dut_flags()}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [2:0]   ro;
    logic [W-1:0] ra, rb;

    #3;
    check_reset_values("por");
    @(negedge clk);
    rst = 1'b0;
    idle_cycle();

    // ADD back-to-back
    single(3'd0, 8'h7F, 8'h01, 1'b1);
    chk("add_ovf_lit", {24'd0, result, dut_flags()}, {24'd0, 8'h80, 4'b1010});
    single(3'd0, 8'hFF, 8'h01, 1'b1);
    chk("add_carry_lit", {24'd0, result, dut_flags()}, {24'd0, 8'h00, 4'b0101});
    idle_cycle();

    // SUB cases
    single(3'd1, 8'h05, 8'h05, 1'b1);
    chk("sub_zero_lit", {24'd0, result, dut_flags()}, {24'd0, 8'h00, 4'b0101});
    single(3'd1, 8'h03, 8'h05, 1'b1);
    chk("sub_borrow_lit", {24'd0, result, dut_flags()}, {24'd0, 8'hFE, 4'b1000});
    single(3'd1, 8'h80, 8'h01, 1'b1);
    chk("sub_ovf_lit", {24'd0, result, dut_flags()}, {24'd0, 8'h7F, 4'b0011});

    // Flag hold across a non-flag-setting op
    single(3'd1, 8'h05, 8'h05, 1'b1);
    single(3'd4, 8'h0F, 8'hF0, 1'b0);
    chk("xor_hold_lit", {24'd0, result, dut_flags()}, {24'd0, 8'hFF, 4'b0101});
    idle_cycle();

    // MUL, with a start poked while busy
    mul(8'h10, 8'h10, 1'b1, 1'b1);
    chk("mul_ovf_lit", {24'd0, result, dut_flags()}, {24'd0, 8'h00, 4'b0110});
    idle_cycle();
    mul(8'h0C, 8'h0B, 1'b1, 1'b0);
    chk("mul_neg_lit", {24'd0, result, dut_flags()}, {24'd0, 8'h84, 4'b1000});
    // Start while done is high is accepted
    single(3'd3, 8'h30, 8'h03, 1'b1);
    idle_cycle();

    // Reset mid-multiply
    op = 3'd5; a = 8'h0C; b = 8'h0B; setFlags = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("rst_mid_mul");
    m_res = '0;
    m_flags = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      idle_cycle();
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
    end
    single(3'd0, 8'h01, 8'h01, 1'b1);
    chk("post_rst_add_lit", {24'd0, result}, {24'd0, 8'h02});
    idle_cycle();

    // Randomized ops against the reference model
    for (int n = 0; n < 150; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 9) < 2) begin
        ra = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'h7F;
      end
      if (ro == 3'd5) mul(ra, rb, 1'($urandom), 1'($urandom));
      else single(ro, ra, rb, 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_flag_unit.md
# alu_flag_unit

- Registered ALU that computes a result and the N/Z/V/C condition flags consumed by the control unit's condition/branch logic.
- Single-cycle for add, subtract and logic ops; multi-cycle iterative shift-add for multiply, with a start/busy/done handshake.
- Flags are written only for flag-setting instructions and otherwise hold, so a later conditional jump evaluates the last flag-setting result.

## Interface
- WIDTH, 32, datapath width in bits (≥4).
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL; 110/111 reserved (treated as AND).
- a, b  in  WIDTH  operands, sampled with start.
- setFlags  in  1  flag-write enable, sampled with start.
- result  out  WIDTH  registered result.
- Nflag, Zflag, Vflag, Cflag  out  1 each  registered flags.
- busy  out  1  multiply in progress.
- done  out  1  one-cycle pulse when result/flags update.

## Operation
- States:
  - IDLE: accepts start.
  - MUL: iterating.
- Reset forces IDLE. result=0, all flags=0, busy=0, done=0, iteration counter=0.
- IDLE, start=1, op≠MUL:
  - Compute and register result.
  - If setFlags=1, register flags; otherwise the flags hold.
  - done=1 next cycle. Stay in IDLE.
- IDLE, start=1, op=MUL:
  - Latch a, b, setFlags. Clear the 2·WIDTH accumulator. Counter=WIDTH. busy=1. Enter MUL.
- MUL:
  - Each cycle: if the multiplier LSB=1, add the shifted multiplicand to the accumulator. Shift the multiplier right and the multiplicand left. Decrement the counter.
  - When the counter reaches 0:
    - result = low WIDTH bits.
    - Flags written if the latched setFlags=1.
    - done=1 next cycle, busy=0, return to IDLE.
- start while busy=1 is ignored, not queued. start in the same cycle done is high is accepted normally.
- Arithmetic is mod 2^WIDTH.
- Flag rules:
  - N = result[WIDTH-1].
  - Z = (result==0).
  - ADD: C = carry out of bit WIDTH-1. V = operands have the same sign and the result has a different sign.
  - SUB (a−b via a+~b+1): C = carry out, i.e. 1 when a≥b unsigned (no borrow). V = operands have different signs and the result sign differs from a.
  - AND/OR/XOR/reserved: C=0, V=0.
  - MUL: C=0, V = 1 if the upper WIDTH bits of the full product are nonzero (unsigned overflow).
- Flags change only on a done cycle with the flag write enabled. result changes on every done cycle.

## Timing
- Single-cycle op: start sampled at edge k. result/flags valid after edge k. done high from edge k to edge k+1.
- MUL: start sampled at edge k. busy high from edge k to edge k+WIDTH. Iterations occur at edges k+1..k+WIDTH. result/flags are valid and done is high from edge k+WIDTH to k+WIDTH+1.
- Throughput:
  - Single-cycle ops: back-to-back, one per cycle.
  - MUL: a new start is accepted at edge k+WIDTH at the earliest.
- rst asserted mid-MUL aborts asynchronously:
  - Outputs return to reset values immediately.
  - No done is produced for the aborted op.
- Outputs are glitch-free registers. The condition unit may sample the flags on any cycle.

## Test plan
- Reset: assert rst mid-cycle → result=0, N=Z=V=C=0, busy=0, done=0 without waiting for clk.
- WIDTH=8 ADD, setFlags=1: 0x7F+0x01 → result=0x80, N=1 Z=0 V=1 C=0. Then 0xFF+0x01 → 0x00, N=0 Z=1 V=0 C=1. done is pulsed once per op, on consecutive cycles.
- WIDTH=8 SUB, setFlags=1: 0x05−0x05 → 0x00, Z=1 C=1 V=0. Then 0x03−0x05 → 0xFE, N=1 C=0. Then 0x80−0x01 → 0x7F, V=1 C=1.
- Flag hold: after the SUB giving Z=1, XOR 0x0F^0xF0 with setFlags=0 → result=0xFF, flags unchanged (Z=1 C=1).
- WIDTH=8 MUL, setFlags=1: 0x10×0x10 → busy=1 for exactly 8 cycles, then result=0x00, Z=1 V=1 C=0, done for one cycle. A start issued while busy is ignored. 0x0C×0x0B → 0x84, N=1 V=0.
- Reset mid-MUL: start MUL 0x0C×0x0B, assert rst after 3 cycles → busy=0, no done. A fresh ADD 0x01+0x01 → 0x02 with done 1 cycle later.
